// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the burst sum accumulator.
// The SUM_ACCUM_SAT_EN macro selects saturating accumulation in the top level.
package sum_accum_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SAT_VALUE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_16bit.sv
// 16-bit ripple-carry adder: a chain of full adders from bit 0 to bit 15.
module ripple_carry_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[16];

endmodule

// File: rtl/sum_accumulator_16bit.sv
// Burst accumulator: sums len samples through the ripple-carry adder and
// returns one total per burst. SUM_ACCUM_SAT_EN selects saturating mode.
module sum_accumulator_16bit
  import sum_accum_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [LEN_W-1:0]  out_carries,
  output logic              out_sat,
  output state_t            dbg_state
);

  // Handshake: a transfer occurs on any rising edge where valid && ready.
  // The input side is ready only in ACCUM; the output side is valid only in
  // DONE and its payload is held until out_ready is seen.

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  carries_q, carries_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              sat_q, sat_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              in_fire;

  ripple_carry_adder_16bit u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_fire = in_valid && (state_q == ACCUM);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carries_d = carries_q;
    rem_d     = rem_q;
    sat_d     = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          carries_d = '0;
          sat_d     = 1'b0;
          rem_d     = len;
          state_d   = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
`ifdef SUM_ACCUM_SAT_EN
          // Once clamped, acc is SAT_VALUE and any non-zero add carries again.
          if (add_cout) begin
            acc_d = SAT_VALUE;
            sat_d = 1'b1;
          end else begin
            acc_d = add_sum;
          end
`else
          acc_d = add_sum;
          if (add_cout) begin
            carries_d = carries_q + LEN_W'(1);
          end
`endif
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      carries_q <= '0;
      rem_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carries_q <= carries_d;
      rem_q     <= rem_d;
      sat_q     <= sat_d;
    end
  end

  // carries_q stays zero in saturating mode and sat_q stays zero otherwise.
  assign in_ready    = (state_q == ACCUM);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_sat     = sat_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sum_accumulator_16bit.sv
// Directed, table-driven bench for sum_accumulator_16bit; honours
// SUM_ACCUM_SAT_EN when choosing expected results.
module tb_sum_accumulator_16bit;
  import sum_accum_pkg::*;

  localparam int LEN_W = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_sum;
  logic [LEN_W-1:0]  out_carries;
  logic              out_sat;
  state_t            dbg_state;

  sum_accumulator_16bit #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_sat     (out_sat),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int               n;
    logic [3:0][15:0] s;
    bit               rep;     // every sample equals s[0]
    bit               toggle;  // in_valid low on odd cycles
    bit               stall;   // hold out_ready low 5 cycles and poke start
    logic [15:0]      sum_w;
    logic [LEN_W-1:0] car_w;
    logic [15:0]      sum_s;
    bit               sat_s;
  } vec_t;

  int n_vec;
  int n_err;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_burst(input vec_t v);
    logic [15:0]      es;
    logic [LEN_W-1:0] ec;
    logic             esat;
    logic [15:0]      got;
    logic             fire;
    int               i;
    int               cyc;
`ifdef SUM_ACCUM_SAT_EN
    es = v.sum_s; ec = '0; esat = v.sat_s;
`else
    es = v.sum_w; ec = v.car_w; esat = 1'b0;
`endif
    exp_q.push_back(es);
    start = 1'b1;
    len   = v.n[LEN_W-1:0];
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    i = 0;
    cyc = 0;
    while (i < v.n && cyc < 200) begin
      in_valid = !(v.toggle && cyc[0]);
      in_data  = v.rep ? v.s[0] : v.s[i & 3];
      if (in_valid) check("in_ready_accum", in_ready, 1);
      else          check("in_ready_idle_cycle", in_ready, 1);
      fire = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (fire) i++;
    end
    in_valid = 1'b0;
    check("accept_count", i, v.n);
    check("out_valid_latency", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    if (v.stall) begin
      for (int k = 0; k < 5; k++) begin
        start = 1'b1;
        len   = LEN_W'(3);
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_sum", out_sum, es);
        check("stall_in_ready", in_ready, 0);
      end
      start = 1'b0;
    end
    got = exp_q.pop_front();
    check("out_sum", out_sum, got);
    check("out_carries", out_carries, ec);
    check("out_sat", out_sat, esat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_take", busy, 0);
    check("out_valid_dropped", out_valid, 0);
  endtask

  vec_t vecs[6];
  vec_t v_fresh;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;

    //                 n   samples                                    rep tog stl sum_w    car sum_s    sat
    vecs[0] = '{3,  {16'h0000, 16'h0003, 16'h0002, 16'h0001}, 0, 0, 0, 16'h0006, 0,  16'h0006, 0};
    vecs[1] = '{2,  {16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, 0, 0, 0, 16'h0001, 1,  16'hFFFF, 1};
    vecs[2] = '{0,  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 0, 0, 16'h0000, 0,  16'h0000, 0};
    vecs[3] = '{4,  {16'h8000, 16'h0F0F, 16'h1111, 16'h1234}, 0, 1, 1, 16'hB254, 0,  16'hB254, 0};
    vecs[4] = '{31, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 1, 0, 0, 16'hFFE1, 30, 16'hFFFF, 1};
    vecs[5] = '{4,  {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 0, 0, 0, 16'h0000, 2,  16'hFFFF, 1};
    v_fresh = '{1,  {16'h0000, 16'h0000, 16'h0000, 16'h0005}, 0, 0, 0, 16'h0005, 0,  16'h0005, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_carries", out_carries, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_state", dbg_state, IDLE);

    for (int k = 0; k < 6; k++) do_burst(vecs[k]);

    // reset mid-burst after 2 of 4 samples of 0x1000
    start = 1'b1;
    len   = LEN_W'(4);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("mid_burst_busy", busy, 1);
    check("mid_burst_sum", out_sum, 16'h2000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_carries", out_carries, 0);
    check("midrst_out_sat", out_sat, 0);

    do_burst(v_fresh);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_accumulator_16bit.md
# sum_accumulator_16bit

Burst accumulator that sits directly downstream of the 16-bit ripple-carry adder datapath: it streams 16-bit samples through `ripple_carry_adder_16bit` against a running accumulator and returns one total per burst. Input and output use valid/ready handshakes. A small FSM sequences each burst, and carry-outs are counted so software can reconstruct the full-width sum.

## Interface
- `LEN_W`, default 5: width of burst length and carry counter; max burst = 2^LEN_W−1 samples
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin burst; sampled only in IDLE
- `len`  in  LEN_W  sample count for the burst, captured with `start`; 0 legal
- `in_valid`  in  1  sample present
- `in_ready`  out  1  block accepts sample
- `in_data`  in  16  sample
- `busy`  out  1  state ≠ IDLE
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_sum`  out  16  accumulated sum (low 16 bits, or saturated)
- `out_carries`  out  LEN_W  number of adder carry-outs during the burst
- `out_sat`  out  1  saturation occurred (see Configuration)

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. `start`=1 clears acc, carry count, sat flag; loads remaining←`len`. Next state is DONE if `len`==0, else ACCUM.
- ACCUM: `in_ready`=1. A sample transfers on `in_valid`&&`in_ready` and updates the registers:
  - acc←adder sum of (acc, `in_data`), cin=0.
  - Carry count +1 if adder cout=1.
  - remaining−1.
  - On the transfer where remaining==1, next state is DONE.
- DONE: `out_valid`=1, and `out_sum`/`out_carries`/`out_sat` are held stable. `out_ready`=1 returns to IDLE.
- `start` outside IDLE is ignored. No queuing.
- Carry count cannot overflow because carries ≤ len−1 < 2^LEN_W.
- Reset values: `in_ready`=0, `busy`=0, `out_valid`=0, `out_sum`=0, `out_carries`=0, `out_sat`=0. State is IDLE.
- `rst` in any state, including mid-burst or while DONE is stalled: all state returns to reset values on the next edge, and any partial result is discarded.

## Timing
- Adder path is combinational acc→sum within one cycle; the result is registered at the transfer edge.
- Throughput: 1 sample/cycle with `in_valid` held high.
- Latency: last sample accepted at edge k → `out_valid`=1 in the cycle after edge k.
- `len`==0: `start` at edge k → `out_valid`=1 after edge k with `out_sum`=0.
- Minimum turnaround: result taken at edge k → IDLE after k → next `start` is accepted at edge k+1.
- `out_valid` never drops without a handshake, except on `rst`.

## Configuration
- Macro `SUM_ACCUM_SAT_EN`.
- Defined:
  - A cout clamps acc to 16'hFFFF and sets a sticky `out_sat`.
  - Later adds operate on 16'hFFFF, so acc stays saturated.
  - `out_carries` is tied 0.
- Undefined:
  - Acc wraps modulo 2^16 and `out_carries` counts couts.
  - `out_sat` is tied 0.

## Structure
- Package `sum_accum_pkg` holds:
  - state enum typedef (IDLE/ACCUM/DONE)
  - `DATA_W`=16
  - `SAT_VALUE`=16'hFFFF
- One sub-module: an instance of the existing `ripple_carry_adder_16bit` with a=acc, b=`in_data`, whose `cout` feeds the carry/sat logic. No other hierarchy.

## Test plan
- `len`=3, samples 0x0001, 0x0002, 0x0003 back-to-back → `out_sum`=0x0006, `out_carries`=0, `out_valid` one cycle after third accept.
- `len`=2, samples 0xFFFF, 0x0002:
  - Without macro → `out_sum`=0x0001, `out_carries`=1, `out_sat`=0.
  - With macro → `out_sum`=0xFFFF, `out_sat`=1.
- `start` with `len`=0 → `out_valid` next cycle, `out_sum`=0, `out_carries`=0, no `in_ready` pulse.
- `len`=4 with `in_valid` toggling every other cycle; then in DONE hold `out_ready`=0 for 5 cycles and pulse `start` → correct sum, outputs stable, `start` ignored, `in_ready`=0.
- `rst` after 2 of 4 samples of 0x1000 → next cycle all outputs at reset values. A fresh `len`=1 burst of 0x0005 then yields `out_sum`=0x0005.
- `len`=31 bursts of 0xFFFF without macro → `out_sum`=0xFFE1, `out_carries`=30.
